// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: load/store width codes, access FSM states and
// the width/alignment legality rule used to raise mem_fault.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Unsigned widths exist only for loads; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic access_illegal(input logic [2:0] funct3,
                                          input logic       is_store,
                                          input logic [1:0] byte_off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = is_store;
      F3_H:    bad = byte_off[0];
      F3_HU:   bad = is_store | byte_off[0];
      F3_W:    bad = (byte_off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready data-memory bus with byte strobes; the access unit is the master.
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            ready;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  // off_i[0] is always 0 for a legal halfword, so only the upper/lower half matters.
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues loads/stores on the request/ready bus,
// stalls the pipeline while memory is slow, and aligns load data for MEM/WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [XLEN-1:0]   ex_addr_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  mem_access_unit_if.master dmem,
  output logic [XLEN-1:0]   load_data_o,
  output logic              mem_stall_o,
  output logic              mem_fault_o
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;

  logic        active, fault, go;
  logic [3:0]  ex_strb;
  logic [31:0] ex_wdata;
  logic        latch_en, cap_en, use_reg, load_en;
  logic [31:0] align_word, align_out;
  logic [1:0]  align_off;
  logic [2:0]  align_f3;

  assign active = ex_valid_i & (ex_mem_read_i ^ ex_mem_write_i);
  assign fault  = (ex_valid_i & ex_mem_read_i & ex_mem_write_i)
                | (active & access_illegal(ex_funct3_i, ex_mem_write_i, ex_addr_i[1:0]));
  assign go     = active & ~fault;

  always_comb begin
    ex_strb  = 4'b1111;
    ex_wdata = ex_store_data_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        ex_strb  = 4'b0001 << ex_addr_i[1:0];
        ex_wdata = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        ex_strb  = 4'b0011 << ex_addr_i[1:0];
        ex_wdata = {2{ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = {addr_q[31:2], 2'b00};
    dmem.wdata = wdata_q;
    dmem.wstrb = 4'b0000;
    mem_stall_o = 1'b0;
    latch_en   = 1'b0;
    cap_en     = 1'b0;
    use_reg    = 1'b0;
    load_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          dmem.req   = 1'b1;
          dmem.we    = ex_mem_write_i;
          dmem.addr  = {ex_addr_i[31:2], 2'b00};
          dmem.wdata = ex_wdata;
          dmem.wstrb = ex_mem_write_i ? ex_strb : 4'b0000;
          latch_en   = 1'b1;
          if (dmem.ready) begin
            load_en = ex_mem_read_i;
          end else begin
            mem_stall_o = 1'b1;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        dmem.req    = 1'b1;
        dmem.we     = we_q;
        dmem.wstrb  = wstrb_q;
        mem_stall_o = 1'b1;
        if (dmem.ready) begin
          cap_en  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // EX/MEM still shows this access here; it must not be issued a second time.
        use_reg = 1'b1;
        load_en = ~we_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      dmem.req    = 1'b0;
      dmem.we     = 1'b0;
      dmem.wstrb  = 4'b0000;
      mem_stall_o = 1'b0;
      load_en     = 1'b0;
    end
  end

  assign align_word = use_reg ? rdata_q        : dmem.rdata;
  assign align_off  = use_reg ? addr_q[1:0]    : ex_addr_i[1:0];
  assign align_f3   = use_reg ? funct3_q       : ex_funct3_i;

  load_align u_load_align (
    .word_i   (align_word),
    .off_i    (align_off),
    .funct3_i (align_f3),
    .data_o   (align_out)
  );

  assign load_data_o = load_en ? align_out : 32'h0;
  assign mem_fault_o = fault & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q   <= ex_addr_i;
        we_q     <= ex_mem_write_i;
        wdata_q  <= ex_wdata;
        wstrb_q  <= ex_mem_write_i ? ex_strb : 4'b0000;
        funct3_q <= ex_funct3_i;
      end
      if (cap_en) begin
        rdata_q <= dmem.rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// against a byte-level reference model of loads, stores, faults and stall timing.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_rd, ex_wr;
  logic [2:0]  ex_f3;
  logic [31:0] ex_addr, ex_sd;
  logic [31:0] load_data;
  logic        mem_stall, mem_fault;

  mem_access_unit_if #(.XLEN(32)) bus ();

  mem_access_unit #(.XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid),
    .ex_mem_read_i   (ex_rd),
    .ex_mem_write_i  (ex_wr),
    .ex_funct3_i     (ex_f3),
    .ex_addr_i       (ex_addr),
    .ex_store_data_i (ex_sd),
    .dmem            (bus.master),
    .load_data_o     (load_data),
    .mem_stall_o     (mem_stall),
    .mem_fault_o     (mem_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;
  int txn      = 0;

  always @(posedge clk) begin
    if (!rst && bus.req && bus.ready) n_accept++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_fault(bit v, bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int nb;
    if (!v) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd == wr) return 1'b0;
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    nb = 1 << f3[1:0];
    return (a % nb) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
    longint w, v;
    int off;
    w = longint'(word);
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: v = (w >> (8 * off)) % 256;
      3'd1, 3'd5: v = (w >> (8 * off)) % 65536;
      default:    v = w;
    endcase
    if (f3 == 3'd0 && v >= 128)   v = v - 256;
    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(logic [2:0] f3, logic [31:0] a);
    int nb, off;
    nb  = 1 << f3[1:0];
    off = int'(a % 4);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    case (f3[1:0])
      2'd0:    return 32'(sd[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(sd[15:0]) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic check_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd);
    check_eq("req",   32'(bus.req), 32'd1);
    check_eq("addr",  bus.addr, a & 32'hFFFF_FFFC);
    check_eq("we",    32'(bus.we), 32'(wr));
    check_eq("wstrb", 32'(bus.wstrb), wr ? 32'(m_strb(f3, a)) : 32'd0);
    if (wr) check_eq("wdata", bus.wdata, m_wdata(f3, sd));
  endtask

  // One EX/MEM access, from the cycle it enters MEM through its RESP cycle.
  task automatic do_access(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rword, input int nwait);
    bit flt, act;
    logic [31:0] exp_ld;
    int stalls;
    flt    = m_fault(v, rd, wr, f3, a);
    act    = v && (rd != wr) && !flt;
    exp_ld = (act && rd) ? m_load(f3, a, rword) : 32'd0;
    stalls = 0;
    txn++;
    @(negedge clk);
    ex_valid = v; ex_rd = rd; ex_wr = wr; ex_f3 = f3; ex_addr = a; ex_sd = sd;
    bus.ready = act ? (nwait == 0) : 1'($urandom);
    bus.rdata = (act && nwait == 0) ? rword : $urandom;
    #2;
    check_eq("fault", 32'(mem_fault), 32'(flt));
    if (!act) begin
      check_eq("idle_req",   32'(bus.req), 32'd0);
      check_eq("idle_stall", 32'(mem_stall), 32'd0);
      check_eq("idle_load",  load_data, 32'd0);
      $display("txn %0d: v=%0d rd=%0d wr=%0d f3=%0d addr=%08h no-access fault=%0d",
               txn, v, rd, wr, f3, a, flt);
      return;
    end
    check_req(wr, f3, a, sd);
    if (nwait == 0) begin
      check_eq("zw_stall", 32'(mem_stall), 32'd0);
      check_eq("zw_load",  load_data, exp_ld);
      $display("txn %0d: %s f3=%0d addr=%08h zero-wait load=%08h",
               txn, wr ? "st" : "ld", f3, a, load_data);
      return;
    end
    if (mem_stall) stalls++;
    for (int i = 1; i <= nwait; i++) begin
      @(negedge clk);
      bus.ready = (i == nwait);
      bus.rdata = (i == nwait) ? rword : $urandom;
      #2;
      check_req(wr, f3, a, sd);
      if (mem_stall) stalls++;
    end
    @(negedge clk);
    bus.ready = 1'($urandom);
    bus.rdata = $urandom;
    #2;
    check_eq("resp_req",   32'(bus.req), 32'd0);
    check_eq("resp_stall", 32'(mem_stall), 32'd0);
    check_eq("resp_load",  load_data, exp_ld);
    check_eq("stall_cycles", 32'(stalls), 32'(nwait + 1));
    $display("txn %0d: %s f3=%0d addr=%08h waits=%0d load=%08h stalls=%0d",
             txn, wr ? "st" : "ld", f3, a, nwait, load_data, stalls);
  endtask

  initial begin
    int acc0;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    // Reset with an access presented: everything must be held quiet.
    rst = 1'b1;
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = 3'd2;
    ex_addr = 32'h101; ex_sd = 32'h0;
    bus.ready = 1'b1; bus.rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #2;
      check_eq("rst_req",   32'(bus.req), 32'd0);
      check_eq("rst_we",    32'(bus.we), 32'd0);
      check_eq("rst_wstrb", 32'(bus.wstrb), 32'd0);
      check_eq("rst_stall", 32'(mem_stall), 32'd0);
      check_eq("rst_fault", 32'(mem_fault), 32'd0);
      check_eq("rst_load",  load_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0;

    do_access(1, 1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h8012_3456, 2);
    do_access(1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 2);
    do_access(1, 0, 1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 3);
    do_access(1, 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    do_access(1, 1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0);

    // Two back-to-back single-wait loads.
    acc0 = n_accept;
    do_access(1, 1, 0, 3'd2, 32'h300, 32'h0, 32'h1111_2222, 1);
    do_access(1, 1, 0, 3'd2, 32'h304, 32'h0, 32'h3333_4444, 1);
    @(negedge clk);
    ex_valid = 1'b0; bus.ready = 1'b0;
    #2;
    check_eq("b2b_accepts", 32'(n_accept - acc0), 32'd2);

    // Reset in the second WAIT cycle abandons the request.
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = 3'd2; ex_addr = 32'h40;
    bus.ready = 1'b0;
    @(negedge clk); #2;
    check_eq("rw_stall0", 32'(mem_stall), 32'd1);
    @(negedge clk); #2;
    check_eq("rw_req1", 32'(bus.req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_eq("rw_req_rst", 32'(bus.req), 32'd0);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; bus.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      check_eq("rw_req_after",   32'(bus.req), 32'd0);
      check_eq("rw_stall_after", 32'(mem_stall), 32'd0);
      check_eq("rw_load_after",  load_data, 32'd0);
      @(negedge clk);
    end
    $display("txn %0d: reset during WAIT, request dropped", ++txn);
    do_access(1, 1, 0, 3'd5, 32'h46, 32'h0, 32'hF00D_8001, 0);

    // Randomized accesses.
    for (int k = 0; k < 80; k++) begin
      bit v, rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int sel;
      v   = ($urandom % 8) != 0;
      sel = $urandom % 10;
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      if (sel == 8) begin rd = 1'b0; wr = 1'b0; end
      f3  = (($urandom % 8) != 0) ? legal_f3[$urandom % 5] : 3'($urandom);
      a   = $urandom;
      if (($urandom % 4) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      do_access(v, rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    @(negedge clk);
    ex_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit, directly upstream of the MEM/WB pipeline register. It takes the access described by the EX/MEM register and drives a request/ready data-memory bus with byte strobes. It aligns and sign- or zero-extends load data into the MEM/WB `MemoryData` input. While the memory is slow it stalls the pipeline and inserts bubbles into MEM/WB. It also flags misaligned or illegal accesses.

## Interface
Parameters:
- `XLEN`, default 32: data and address width. Only 32 is supported.

Ports:
- `clk`: in, 1. Clock.
- `rst`: in, 1. Reset: synchronous, active-high.
- `ex_valid`: in, 1. EX/MEM holds a real instruction, not a bubble.
- `ex_mem_read`: in, 1. Load.
- `ex_mem_write`: in, 1. Store.
- `ex_funct3`: in, 3. Access width: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. For stores, 000/001/010 mean sb/sh/sw.
- `ex_addr`: in, 32. Byte address (EX/MEM ALU result).
- `ex_store_data`: in, 32. rs2 value.
- `dmem_req`: out, 1. Request valid.
- `dmem_we`: out, 1. Write enable.
- `dmem_addr`: out, 32. Word address; bits [1:0] are always 00.
- `dmem_wdata`: out, 32. Store data, replicated into lanes.
- `dmem_wstrb`: out, 4. Byte-lane enables; 0 for reads.
- `dmem_ready`: in, 1. Memory completes the current request this cycle.
- `dmem_rdata`: in, 32. Read word; valid when `dmem_ready` is high.
- `load_data`: out, 32. Aligned and extended load result, feeding MEM/WB `MemoryData`.
- `mem_stall`: out, 1. Holds PC, IF/ID, ID/EX and EX/MEM, and asserts `MEMWBFlush`.
- `mem_fault`: out, 1. Misaligned access or illegal funct3. The access is suppressed.

## Operation
Access is active when `ex_valid` is high and exactly one of `ex_mem_read`/`ex_mem_write` is high.

Fault:
- Raised for an active access with halfword `addr[0]=1`, word `addr[1:0]≠0`, funct3 ∈ {011, 110, 111}, or any store funct3 above 010.
- Raised when `ex_valid` is high with read and write both high.
- Effect: `mem_fault=1` combinationally; no request; `mem_stall=0`; `load_data=0`.

Store lanes:
- sb: `wstrb = 0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
- sh: `wstrb = 0011 << addr[1:0]`, `wdata = {2{sd[15:0]}}`.
- sw: `wstrb = 1111`, `wdata = sd`.

Load: select byte or halfword `rdata >> (8*addr[1:0])`, then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw passes the word through.

FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Active, non-faulting access: `dmem_*` driven combinationally from the `ex_*` inputs.
  - Latch addr, we, wdata, wstrb, funct3.
  - If `dmem_ready` is high in the same cycle: zero-wait. `load_data` comes from `dmem_rdata` combinationally, `mem_stall=0`, stay in IDLE.
  - Otherwise: `mem_stall=1`, go to WAIT.
- WAIT:
  - `dmem_req=1` with the latched fields; `mem_stall=1`.
  - On `dmem_ready`: register `dmem_rdata` and go to RESP. `mem_stall` stays 1 in this cycle.
- RESP:
  - `dmem_req=0`, `mem_stall=0`.
  - `load_data` is formed from the registered word and latched funct3/addr; MEM/WB captures it at the next edge.
  - Go to IDLE.
  - The request is never re-issued, even though EX/MEM still shows the same instruction.
- Non-load accesses and stores: `load_data=0`.

## Timing
- Reset:
  - State IDLE; latched fields and data register 0.
  - While `rst` is high, `dmem_req`, `dmem_we`, `dmem_wstrb`, `mem_stall`, `mem_fault` and `load_data` are forced to 0.
- Latency from access entering MEM to MEM/WB capture: zero-wait is 1 cycle, no stall. With N≥1 wait cycles it is N+2 cycles, with `mem_stall` high for N+1 cycles.
- Handshake: once asserted, `dmem_req` and its fields stay stable until the cycle with `dmem_ready`. `dmem_ready` is ignored while `dmem_req=0`.
- Reset mid-WAIT: the next state is IDLE, the outstanding request is abandoned, and the memory is reset alongside.
- Back-to-back accesses: the access that follows a RESP cycle enters IDLE on the next cycle. There is no dead cycle beyond RESP.

## Structure
- Shared pipeline package holds:
  - funct3 width constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `mem_state_t` enum {IDLE, WAIT, RESP}.
- One combinational sub-module, `load_align`, takes (word, addr[1:0], funct3) and returns the extended value. It is instantiated once, muxed between `dmem_rdata` and the registered word.

## Test plan
- Zero-wait lw at address 0x100 with rdata 0xDEADBEEF: `load_data`=0xDEADBEEF the same cycle; `mem_stall` never high.
- lb at 0x103 with rdata 0x80123456 and 2 wait cycles: `mem_stall` high 3 cycles, then `load_data`=0xFFFFFF80 in RESP. lbu with the same inputs gives 0x00000080.
- sh at 0x202 with store data 0x0000ABCD: `dmem_addr`=0x200, `wstrb`=1100, `wdata`=0xABCDABCD, `we`=1, and the fields are held through 3 wait cycles.
- lw at 0x101: `mem_fault`=1, `dmem_req`=0, `mem_stall`=0, `load_data`=0.
- `rst` asserted in the second WAIT cycle: the next cycle `dmem_req`=0, state IDLE, `mem_stall`=0, and a later `dmem_ready` is ignored.
- Two consecutive lw, each with 1 wait cycle: exactly two requests, each RESP followed immediately by the next IDLE request, and no duplicate request in RESP.
